uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of byte requesters sharing one UART transmitter (2..8).
REQ-002 SHALL have parameter BIT, default 8, data word width, equal to the transmitter's BIT.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535, idle cycles after which a held packet lock is forcibly released.
REQ-004 SHALL have ports; the design has one clock, and reset is asynchronous and active-low:
  clk            in   1           system clock, rising edge
  rst_n          in   1           asynchronous active-low reset
  req_valid      in   NREQ        per-requester byte valid
  req_data       in   NREQ*BIT    requester i data at [i*BIT +: BIT]
  req_last       in   NREQ        byte is last of the requester's packet
  req_ready      out  NREQ        one-hot; byte i taken when req_valid[i] & req_ready[i]
  grant          out  NREQ        one-hot owner of current byte/packet, 0 when none
  tx_data        out  BIT         byte to transmitter
  tx_data_valid  out  1           byte offer to transmitter
  tx_data_ready  in   1           transmitter idle/ready
  busy           out  1           byte in flight (state != S_IDLE)
  lock_timeout   out  1           one-cycle pulse on forced lock release

Function
REQ-005 SHALL implement states S_IDLE, S_SEND, S_WAIT_BUSY, S_WAIT_DONE.
REQ-006 In S_IDLE, when unlocked, SHALL select the first valid requester, round-robin, starting at index rr_ptr and wrapping NREQ-1 to 0.
REQ-007 In S_IDLE, when locked, SHALL consider only the lock owner; other requesters SHALL NOT be granted.
REQ-008 req_ready SHALL be combinational, asserted only in S_IDLE, only for the selected requester, and only while its req_valid is high.
REQ-009 On transfer, SHALL register tx_data <= selected data, grant <= one-hot of the selected requester, and last flag <= req_last, and SHALL move to S_SEND.
REQ-010 tx_data_valid SHALL be 1 exactly while in S_SEND; tx_data SHALL stay stable from S_SEND until the next transfer.
REQ-011 In S_SEND with tx_data_ready=1, SHALL move to S_WAIT_BUSY; otherwise SHALL stay in S_SEND.
REQ-012 In S_WAIT_BUSY, SHALL move to S_WAIT_DONE when tx_data_ready=0.
REQ-013 In S_WAIT_DONE, SHALL move to S_IDLE when tx_data_ready=1 (stop bit finished).
REQ-014 On leaving S_WAIT_DONE with last=1: lock cleared, rr_ptr <= owner+1 (mod NREQ), grant <= 0.
REQ-015 On leaving S_WAIT_DONE with last=0: lock set to owner, grant held, rr_ptr unchanged.
REQ-016 Minimum gap SHALL be zero cycles, i.e. a requester valid in the S_IDLE cycle is taken that same cycle.
REQ-017 The lock idle counter SHALL count cycles in S_IDLE while locked and the owner's req_valid=0, and SHALL reset on any transfer.
REQ-018 When the counter reaches LOCK_TIMEOUT-1: lock cleared, grant <= 0, rr_ptr <= owner+1, lock_timeout pulses for one cycle.
REQ-019 Counter width SHALL be $clog2(LOCK_TIMEOUT+1); the counter SHALL NOT wrap.
REQ-020 A requester dropping req_valid before handshake SHALL be legal; selection is recomputed every S_IDLE cycle.

Reset
REQ-021 rst_n=0 SHALL asynchronously force: state S_IDLE, tx_data 0, tx_data_valid 0, grant 0, busy 0, lock_timeout 0, lock cleared, rr_ptr 0, counter 0.
REQ-022 Reset mid-byte SHALL abandon the byte; the transmitter SHALL share the same reset.

Structure
REQ-023 State encodings SHALL live in a shared package uart_pkg, alongside the transmitter constants.
REQ-024 Round-robin selection SHALL be the sub-module rr_select (inputs: request vector and pointer; outputs: one-hot and index), combinational.

Verification
REQ-025 Reset release, req_valid=4'b0001, data 0x55, last=1 -> req_ready[0] same cycle, tx_data=0x55 with valid, grant=0001 until stop bit done, then grant=0.
REQ-026 req_valid=4'b1111 held, all last=1 -> bytes granted in order 0,1,2,3,0, one byte per UART frame.
REQ-027 Req1 sends 3-byte packet (last on third) while req0 and req2 are valid -> 3 consecutive req1 bytes, then req2 granted, then req0.
REQ-028 Req1 locked (last=0), then idle, LOCK_TIMEOUT=16 -> lock_timeout pulse after 16 S_IDLE cycles, then pending req2 granted.
REQ-029 tx_data_ready held 0 in S_SEND for 10 cycles -> tx_data_valid stays 1, tx_data stable, no req_ready.
REQ-030 rst_n asserted in S_WAIT_DONE -> all outputs 0 immediately; after release, req0 wins over a previously locked req3.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte arbiter state encoding and transmitter frame constants.
package uart_pkg;

   // State | meaning
   // S_IDLE      | no byte in flight, selecting a requester
   // S_SEND      | byte offered to transmitter, waiting for tx_data_ready
   // S_WAIT_BUSY | byte accepted, waiting for transmitter to go busy
   // S_WAIT_DONE | transmitter shifting, waiting for stop bit to finish
   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_SEND      = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } arb_state_t;

   localparam int UART_BIT        = 8;
   localparam int UART_START_BITS = 1;
   localparam int UART_STOP_BITS  = 1;
   localparam int UART_FRAME_BITS = UART_START_BITS + UART_BIT + UART_STOP_BITS;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping N-1 to 0.
module rr_select #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);

   // scan N positions starting at ptr, keep the first hit
   always_comb begin
      int pos;
      pos    = 0;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int k = 0; k < N; k++) begin
         pos = int'(ptr) + k;
         if (pos >= N) pos = pos - N;
         if (!any && req[pos]) begin
            any         = 1'b1;
            onehot[pos] = 1'b1;
            idx         = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte requesters with round-robin
// selection and packet locking; a lock left idle too long is forcibly released.
//
// State       | meaning
// S_IDLE      | nothing in flight; pick requester (lock owner only while locked)
// S_SEND      | tx_data_valid high, waiting for transmitter to take the byte
// S_WAIT_BUSY | byte taken, waiting for tx_data_ready to drop
// S_WAIT_DONE | frame shifting out, waiting for tx_data_ready to return
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int BIT          = UART_BIT,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*BIT-1:0] req_data,
   input  logic [NREQ-1:0]     req_last,
   output logic [NREQ-1:0]     req_ready,
   output logic [NREQ-1:0]     grant,
   output logic [BIT-1:0]      tx_data,
   output logic                tx_data_valid,
   input  logic                tx_data_ready,
   output logic                busy,
   output logic                lock_timeout
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_TC = CW'(LOCK_TIMEOUT - 1);

   arb_state_t      state;
   logic            locked;
   logic            last_q;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   owner_next;
   logic [IW-1:0]   rr_ptr;
   logic [CW-1:0]   lock_cnt;
   logic            owner_idle;
   logic [NREQ-1:0] owner_mask;
   logic [NREQ-1:0] cand;
   logic [NREQ-1:0] sel_onehot;
   logic [IW-1:0]   sel_idx;
   logic            sel_any;

   // while locked only the owner may compete; selection is redone every cycle
   always_comb begin
      owner_mask        = '0;
      owner_mask[owner] = 1'b1;
      cand              = locked ? (req_valid & owner_mask) : req_valid;
   end

   rr_select #(.N(NREQ)) u_rr_select (
      .req    (cand),
      .ptr    (rr_ptr),
      .onehot (sel_onehot),
      .idx    (sel_idx),
      .any    (sel_any)
   );

   assign owner_next = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
   assign owner_idle = locked && !req_valid[owner];
   assign req_ready  = (state == S_IDLE) ? sel_onehot : '0;
   assign busy       = (state != S_IDLE);

   // arbitration FSM, lock bookkeeping and lock idle timer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         tx_data       <= '0;
         tx_data_valid <= 1'b0;
         grant         <= '0;
         lock_timeout  <= 1'b0;
         locked        <= 1'b0;
         owner         <= '0;
         last_q        <= 1'b0;
         rr_ptr        <= '0;
         lock_cnt      <= '0;
      end else begin
         lock_timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (sel_any) begin
                  tx_data       <= req_data[int'(sel_idx) * BIT +: BIT];
                  grant         <= sel_onehot;
                  owner         <= sel_idx;
                  last_q        <= req_last[sel_idx];
                  lock_cnt      <= '0;
                  tx_data_valid <= 1'b1;
                  state         <= S_SEND;
               end else if (owner_idle) begin
                  // counter stops at the terminal count, so it never wraps
                  if (lock_cnt == CNT_TC) begin
                     locked       <= 1'b0;
                     grant        <= '0;
                     rr_ptr       <= owner_next;
                     lock_cnt     <= '0;
                     lock_timeout <= 1'b1;
                  end else begin
                     lock_cnt <= lock_cnt + CW'(1);
                  end
               end
            end
            S_SEND: begin
               if (tx_data_ready) begin
                  tx_data_valid <= 1'b0;
                  state         <= S_WAIT_BUSY;
               end
            end
            S_WAIT_BUSY: begin
               if (!tx_data_ready) state <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               // ready returning means the stop bit has gone out
               if (tx_data_ready) begin
                  state <= S_IDLE;
                  if (last_q) begin
                     locked <= 1'b0;
                     rr_ptr <= owner_next;
                     grant  <= '0;
                  end else begin
                     locked <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
